clock_period_meter: RTL

Measures the period of a slow, asynchronous clock-like signal (e.g. the divided SD/SPI clock from `frequencyDivider`) in cycles of the system clock. The result is a cycle count plus a one-cycle valid strobe and a timeout flag. It is the observing end of the divider: it reads back the divided clock so firmware and benches can confirm the actual divide ratio.

---
 rtl/clock_period_meter.sv | 115 +++++++++++
 1 files changed

// File: rtl/clock_period_meter.sv
// Measures the rising-to-rising period of an asynchronous slow clock in inputCLK cycles.
// Define CLOCK_PERIOD_METER_HIGH_TIME_EN to add the highTime output (high-phase length).
module clock_period_meter #(
  parameter int bitsNumber = 16
) (
  input  logic                  inputCLK,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  measuredCLK,
  output logic [bitsNumber-1:0] period,
  output logic                  periodValid,
  output logic                  timeout
`ifdef CLOCK_PERIOD_METER_HIGH_TIME_EN
  ,
  output logic [bitsNumber-1:0] highTime
`endif
);

  typedef enum logic {
    IDLE,
    MEASURE
  } stateType;

  localparam logic [bitsNumber-1:0] countOne = bitsNumber'(1);
  localparam logic [bitsNumber-1:0] countMax = '1;

  stateType              state;
  logic [bitsNumber-1:0] count;
  logic                  s1;
  logic                  s2;
  logic                  s3;
  logic                  rise;

  assign rise = s2 & ~s3;

  // Two-flop synchronizer plus a history flop for edge detection; runs regardless of enable.
  always_ff @(posedge inputCLK or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= measuredCLK;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // The first rise only arms the counter; later rises publish the count and restart it.
  // A rise in the saturating cycle still wins, so the full counter range is measurable.
  always_ff @(posedge inputCLK or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= countOne;
      period      <= '0;
      periodValid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      periodValid <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        count <= countOne;
      end else begin
        case (state)
          IDLE: begin
            count <= countOne;
            if (rise) begin
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              period      <= count;
              periodValid <= 1'b1;
              timeout     <= 1'b0;
              count       <= countOne;
            end else if (count == countMax) begin
              timeout <= 1'b1;
              state   <= IDLE;
              count   <= countOne;
            end else begin
              count <= count + countOne;
            end
          end
          default: begin
            state <= IDLE;
            count <= countOne;
          end
        endcase
      end
    end
  end

`ifdef CLOCK_PERIOD_METER_HIGH_TIME_EN
  logic [bitsNumber-1:0] highCount;

  // highCount restarts on rise and only advances while s2 is high, so it stays frozen after the fall.
  always_ff @(posedge inputCLK or negedge reset) begin
    if (!reset) begin
      highCount <= countOne;
      highTime  <= '0;
    end else begin
      if (rise) begin
        highCount <= countOne;
      end else if (s2 && (highCount != countMax)) begin
        highCount <= highCount + countOne;
      end
      if (enable && (state == MEASURE) && rise) begin
        highTime <= highCount;
      end
    end
  end
`endif

endmodule
